ahb2apb_bridge_gen: RTL and testbench

Parametrised AHB-to-APB bridge that turns single AHB-Lite transfers into APB SETUP/ACCESS sequences for up to NUM_SLV peripherals. It sits between the AHB interconnect and the APB peripheral bank, decodes a contiguous window of equal-size slave regions, and adds APB wait states (Pready). Out-of-range addresses and peripheral errors return a two-cycle AHB ERROR response.

---
 rtl/ahb2apb_bridge_gen.sv | 158 +++++++++++++++
 tb/tb_ahb2apb_bridge_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_gen.sv
// AHB-Lite to APB bridge: single AHB transfers become APB SETUP/ACCESS
// sequences to one of NUM_SLV equal-size slave regions starting at BASE_ADDR.
// Out-of-range addresses produce a two-cycle AHB ERROR response.
// Optional feature: define APB_PSLVERR_EN to turn Pslverr into an AHB ERROR.
module ahb2apb_bridge_gen #(
    parameter int unsigned       ADDR_W        = 32,
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       NUM_SLV       = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned       SLV_SIZE_LOG2 = 26
) (
    input  logic               Hclk_i,
    input  logic               Hreset_i,
    input  logic               Hwrite_i,
    input  logic               Hreadyin_i,
    input  logic [1:0]         Htrans_i,
    input  logic [ADDR_W-1:0]  Haddr_i,
    input  logic [DATA_W-1:0]  Hwdata_i,
    input  logic [DATA_W-1:0]  Prdata_i,
    input  logic               Pready_i,
    input  logic               Pslverr_i,
    output logic [NUM_SLV-1:0] Pselx_o,
    output logic [ADDR_W-1:0]  Paddr_o,
    output logic [DATA_W-1:0]  Pwdata_o,
    output logic               Pwrite_o,
    output logic               Penable_o,
    output logic               Hreadyout_o,
    output logic [1:0]         Hresp_o,
    output logic [DATA_W-1:0]  Hrdata_o
);

    localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [2:0] {
        StIdle, StWwait, StSetup, StAccess, StErr1, StErr2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IdxW-1:0]     idx_q, idx_d;

    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   idx_full;
    logic                in_range;
    logic                valid;
    logic                capture;
    logic                slv_err;
    logic [NUM_SLV-1:0]  sel_onehot;
    logic                unused_sig;

`ifdef APB_PSLVERR_EN
    assign slv_err    = Pslverr_i;
    assign unused_sig = Htrans_i[0];
`else
    // Port kept for a uniform interface; errors from peripherals are dropped.
    assign slv_err    = 1'b0;
    assign unused_sig = Htrans_i[0] ^ Pslverr_i;
`endif

    // Address decode of the current AHB address phase
    always_comb begin
        off      = Haddr_i - BASE_ADDR;
        idx_full = off >> SLV_SIZE_LOG2;
        in_range = (Haddr_i >= BASE_ADDR) && (idx_full < ADDR_W'(NUM_SLV));
        valid    = Hreadyin_i && Htrans_i[1];
    end

    assign sel_onehot = NUM_SLV'(1) << idx_q;

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        idx_d       = idx_q;
        Pselx_o     = '0;
        Penable_o   = 1'b0;
        Hreadyout_o = 1'b1;
        Hresp_o     = 2'b00;
        capture     = 1'b0;

        unique case (state_q)
            StIdle: capture = 1'b1;
            StWwait: begin
                Hreadyout_o = 1'b0;
                pwdata_d    = Hwdata_i;
                state_d     = StSetup;
            end
            StSetup: begin
                Pselx_o     = sel_onehot;
                Hreadyout_o = 1'b0;
                state_d     = StAccess;
            end
            StAccess: begin
                Pselx_o   = sel_onehot;
                Penable_o = 1'b1;
                if (!Pready_i) begin
                    Hreadyout_o = 1'b0;
                end else if (slv_err) begin
                    Hreadyout_o = 1'b0;
                    Hresp_o     = 2'b01;
                    state_d     = StErr2;
                end else begin
                    capture = 1'b1;
                end
            end
            StErr1: begin
                Hreadyout_o = 1'b0;
                Hresp_o     = 2'b01;
                state_d     = StErr2;
            end
            StErr2: begin
                Hresp_o = 2'b01;
                capture = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Any cycle that ends with Hreadyout=1 may accept the next address phase
        if (capture) begin
            state_d = StIdle;
            if (valid) begin
                paddr_d  = Haddr_i;
                pwrite_d = Hwrite_i;
                idx_d    = idx_full[IdxW-1:0];
                if (!in_range)     state_d = StErr1;
                else if (Hwrite_i) state_d = StWwait;
                else               state_d = StSetup;
            end
        end
    end

    // State and APB address/data registers, synchronous reset
    always_ff @(posedge Hclk_i) begin
        if (Hreset_i) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
        end
    end

    assign Paddr_o  = paddr_q;
    assign Pwdata_o = pwdata_q;
    assign Pwrite_o = pwrite_q;
    assign Hrdata_o = (state_q == StAccess) ? Prdata_i : '0;

endmodule

// File: tb/tb_ahb2apb_bridge_gen.sv
// Scoreboard bench for ahb2apb_bridge_gen: the stimulus process pushes the
// hand-computed expected outputs for each cycle; a monitor pops and compares
// on the falling edge.
module tb_ahb2apb_bridge_gen;

    logic        clk = 1'b0;
    logic        hreset, hwrite, hreadyin, pready, pslverr;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, prdata;
    logic [2:0]  pselx;
    logic [31:0] paddr, pwdata, hrdata;
    logic        pwrite, penable, hreadyout;
    logic [1:0]  hresp;

    always #5 clk = ~clk;

    ahb2apb_bridge_gen dut (
        .Hclk_i      (clk),
        .Hreset_i    (hreset),
        .Hwrite_i    (hwrite),
        .Hreadyin_i  (hreadyin),
        .Htrans_i    (htrans),
        .Haddr_i     (haddr),
        .Hwdata_i    (hwdata),
        .Prdata_i    (prdata),
        .Pready_i    (pready),
        .Pslverr_i   (pslverr),
        .Pselx_o     (pselx),
        .Paddr_o     (paddr),
        .Pwdata_o    (pwdata),
        .Pwrite_o    (pwrite),
        .Penable_o   (penable),
        .Hreadyout_o (hreadyout),
        .Hresp_o     (hresp),
        .Hrdata_o    (hrdata)
    );

    typedef struct packed {
        logic [2:0]  psel;
        logic        pen;
        logic        hrdy;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } obs_t;

    obs_t  exp_q[$];
    string nm_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

`ifdef APB_PSLVERR_EN
    localparam bit SlvErrEn = 1'b1;
`else
    localparam bit SlvErrEn = 1'b0;
`endif

    function automatic string fmt(obs_t o);
        return $sformatf("psel=%b pen=%b hrdy=%b hresp=%b hrdata=%h paddr=%h pwrite=%b pwdata=%h",
                         o.psel, o.pen, o.hrdy, o.hresp, o.hrdata, o.paddr, o.pwrite, o.pwdata);
    endfunction

    // Monitor: compare one expected record per cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e, a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = '{psel: pselx, pen: penable, hrdy: hreadyout, hresp: hresp, hrdata: hrdata,
                  paddr: paddr, pwrite: pwrite, pwdata: pwdata};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %s / exp %s", n, fmt(a), fmt(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                       input logic [31:0] wd);
        htrans = tr;
        hwrite = wr;
        haddr  = ad;
        hwdata = wd;
    endtask

    task automatic ex(input string nm, input logic [2:0] ps, input logic pe, input logic hr,
                      input logic [1:0] rs, input logic [31:0] rd, input logic [31:0] pa,
                      input logic pw, input logic [31:0] wd);
        obs_t o;
        o = '{psel: ps, pen: pe, hrdy: hr, hresp: rs, hrdata: rd, paddr: pa, pwrite: pw,
              pwdata: wd};
        exp_q.push_back(o);
        nm_q.push_back(nm);
    endtask

    initial begin
        hreset = 1'b1; hreadyin = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = '0;
        drv(2'b00, 1'b0, 32'h0, 32'h0);

        // Reset and ignored transfer types
        step(); ex("reset", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); hreset = 1'b0; ex("idle", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); drv(2'b10, 0, 32'h8000_0000, 0); hreadyin = 1'b0;
        ex("rdyin_low", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); hreadyin = 1'b1; drv(2'b01, 0, 32'h8000_0000, 0);
        ex("rdyin_ignored", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); drv(2'b00, 0, 32'h0, 0);
        ex("busy_ignored", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);

        // Read slave 1, no wait states
        step(); drv(2'b10, 0, 32'h8400_0010, 0);
        ex("rd1_cap", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); drv(2'b00, 0, 0, 0); prdata = 32'hDEAD_BEEF;
        ex("rd1_setup", 3'b010, 0, 0, 2'b00, 0, 32'h8400_0010, 0, 0);
        step(); ex("rd1_access", 3'b010, 1, 1, 2'b00, 32'hDEAD_BEEF, 32'h8400_0010, 0, 0);
        step(); ex("rd1_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8400_0010, 0, 0);

        // Write slave 2
        step(); drv(2'b10, 1, 32'h8800_0004, 0);
        ex("wr2_cap", 3'b000, 0, 1, 2'b00, 0, 32'h8400_0010, 0, 0);
        step(); drv(2'b00, 0, 0, 32'h1234_5678);
        ex("wr2_wwait", 3'b000, 0, 0, 2'b00, 0, 32'h8800_0004, 1, 0);
        step(); hwdata = 32'h0;
        ex("wr2_setup", 3'b100, 0, 0, 2'b00, 0, 32'h8800_0004, 1, 32'h1234_5678);
        step(); ex("wr2_access", 3'b100, 1, 1, 2'b00, 32'hDEAD_BEEF, 32'h8800_0004, 1,
                   32'h1234_5678);
        step(); ex("wr2_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8800_0004, 1, 32'h1234_5678);

        // Read slave 0 with three wait states
        step(); drv(2'b10, 0, 32'h8000_0000, 0);
        ex("rdw_cap", 3'b000, 0, 1, 2'b00, 0, 32'h8800_0004, 1, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 0); pready = 1'b0; prdata = 32'hCAFE_F00D;
        ex("rdw_setup", 3'b001, 0, 0, 2'b00, 0, 32'h8000_0000, 0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            ex($sformatf("rdw_wait%0d", i), 3'b001, 1, 0, 2'b00, 32'hCAFE_F00D, 32'h8000_0000,
               0, 32'h1234_5678);
        end
        step(); pready = 1'b1;
        ex("rdw_done", 3'b001, 1, 1, 2'b00, 32'hCAFE_F00D, 32'h8000_0000, 0, 32'h1234_5678);
        step(); ex("rdw_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8000_0000, 0, 32'h1234_5678);

        // Out-of-range write, then a read captured during ERR2
        step(); drv(2'b10, 1, 32'h8C00_0000, 0);
        ex("oor_cap", 3'b000, 0, 1, 2'b00, 0, 32'h8000_0000, 0, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 32'h5555_5555);
        ex("oor_err1", 3'b000, 0, 0, 2'b01, 0, 32'h8C00_0000, 1, 32'h1234_5678);
        step(); drv(2'b10, 0, 32'h8000_0004, 0);
        ex("oor_err2", 3'b000, 0, 1, 2'b01, 0, 32'h8C00_0000, 1, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 0); prdata = 32'h1111_2222;
        ex("err2_b2b_setup", 3'b001, 0, 0, 2'b00, 0, 32'h8000_0004, 0, 32'h1234_5678);
        step(); ex("err2_b2b_access", 3'b001, 1, 1, 2'b00, 32'h1111_2222, 32'h8000_0004, 0,
                   32'h1234_5678);
        step(); ex("err2_b2b_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8000_0004, 0, 32'h1234_5678);

        // Address below the window
        step(); drv(2'b11, 0, 32'h7FFF_FFFC, 0);
        ex("low_cap", 3'b000, 0, 1, 2'b00, 0, 32'h8000_0004, 0, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 0);
        ex("low_err1", 3'b000, 0, 0, 2'b01, 0, 32'h7FFF_FFFC, 0, 32'h1234_5678);
        step(); ex("low_err2", 3'b000, 0, 1, 2'b01, 0, 32'h7FFF_FFFC, 0, 32'h1234_5678);
        step(); ex("low_idle", 3'b000, 0, 1, 2'b00, 0, 32'h7FFF_FFFC, 0, 32'h1234_5678);

        // Peripheral error on a read of slave 1
        step(); drv(2'b10, 0, 32'h8400_0020, 0);
        ex("slv_cap", 3'b000, 0, 1, 2'b00, 0, 32'h7FFF_FFFC, 0, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 0); pslverr = 1'b1;
        ex("slv_setup", 3'b010, 0, 0, 2'b00, 0, 32'h8400_0020, 0, 32'h1234_5678);
        step();
        if (SlvErrEn) ex("slv_access", 3'b010, 1, 0, 2'b01, 32'h1111_2222, 32'h8400_0020, 0,
                         32'h1234_5678);
        else          ex("slv_access", 3'b010, 1, 1, 2'b00, 32'h1111_2222, 32'h8400_0020, 0,
                         32'h1234_5678);
        step(); pslverr = 1'b0;
        if (SlvErrEn) ex("slv_err2", 3'b000, 0, 1, 2'b01, 0, 32'h8400_0020, 0, 32'h1234_5678);
        else          ex("slv_err2", 3'b000, 0, 1, 2'b00, 0, 32'h8400_0020, 0, 32'h1234_5678);
        step(); ex("slv_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8400_0020, 0, 32'h1234_5678);

        // Write then back-to-back read
        step(); drv(2'b10, 1, 32'h8000_0008, 0);
        ex("b2b_wcap", 3'b000, 0, 1, 2'b00, 0, 32'h8400_0020, 0, 32'h1234_5678);
        step(); drv(2'b00, 0, 0, 32'hAAAA_5555);
        ex("b2b_wwait", 3'b000, 0, 0, 2'b00, 0, 32'h8000_0008, 1, 32'h1234_5678);
        step(); hwdata = 32'h0;
        ex("b2b_wsetup", 3'b001, 0, 0, 2'b00, 0, 32'h8000_0008, 1, 32'hAAAA_5555);
        step(); drv(2'b10, 0, 32'h8800_0000, 0);
        ex("b2b_waccess", 3'b001, 1, 1, 2'b00, 32'h1111_2222, 32'h8000_0008, 1, 32'hAAAA_5555);
        step(); drv(2'b00, 0, 0, 0); prdata = 32'h3333_4444;
        ex("b2b_rsetup", 3'b100, 0, 0, 2'b00, 0, 32'h8800_0000, 0, 32'hAAAA_5555);
        step(); ex("b2b_raccess", 3'b100, 1, 1, 2'b00, 32'h3333_4444, 32'h8800_0000, 0,
                   32'hAAAA_5555);
        step(); ex("b2b_idle", 3'b000, 0, 1, 2'b00, 0, 32'h8800_0000, 0, 32'hAAAA_5555);

        // Reset asserted during SETUP abandons the transfer
        step(); drv(2'b10, 0, 32'h8400_0000, 0);
        ex("rst_cap", 3'b000, 0, 1, 2'b00, 0, 32'h8800_0000, 0, 32'hAAAA_5555);
        step(); drv(2'b00, 0, 0, 0); hreset = 1'b1;
        ex("rst_setup", 3'b010, 0, 0, 2'b00, 0, 32'h8400_0000, 0, 32'hAAAA_5555);
        step(); hreset = 1'b0;
        ex("rst_applied", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);
        step(); ex("rst_idle", 3'b000, 0, 1, 2'b00, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
